// File: rtl/micro_pkg.sv
// Shared definitions for the 4-bit computational unit's control path:
// FSM states, opcode fields, source/enable codes and the destination map.
package micro_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LATCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  // Opcode prefixes, compared against the top bits of ir
  localparam logic [1:0] OPC_MOVE = 2'b10;
  localparam logic [2:0] OPC_ALU  = 3'b110;
  localparam logic [3:0] OPC_JMP  = 4'b1110;
  localparam logic [3:0] OPC_JNZ  = 4'b1111;

  // ALU nibbles that leave r and the zero flag untouched
  localparam logic [3:0] ALU_NOP_A = 4'b1000;
  localparam logic [3:0] ALU_NOP_B = 4'b1111;

  // Data-bus source select codes
  localparam logic [3:0] SRC_X0     = 4'd0;
  localparam logic [3:0] SRC_X1     = 4'd1;
  localparam logic [3:0] SRC_Y0     = 4'd2;
  localparam logic [3:0] SRC_Y1     = 4'd3;
  localparam logic [3:0] SRC_R      = 4'd4;
  localparam logic [3:0] SRC_M      = 4'd5;
  localparam logic [3:0] SRC_I      = 4'd6;
  localparam logic [3:0] SRC_DM     = 4'd7;
  localparam logic [3:0] SRC_NIBBLE = 4'd8;
  localparam logic [3:0] SRC_I_PINS = 4'd9;

  // reg_en bit positions
  localparam int EN_X0    = 0;
  localparam int EN_X1    = 1;
  localparam int EN_Y0    = 2;
  localparam int EN_Y1    = 3;
  localparam int EN_R     = 4;
  localparam int EN_M     = 5;
  localparam int EN_I     = 6;
  localparam int EN_DM    = 7;
  localparam int EN_O_REG = 8;

  // Destination codes with special handling
  localparam logic [2:0] DST_O_REG = 3'd4;
  localparam logic [2:0] DST_I     = 3'd6;
  localparam logic [2:0] DST_DM    = 3'd7;

  // Destination code 4 is o_reg, not r: r is written only by ALU instructions.
  function automatic logic [8:0] dst_onehot(input logic [2:0] dst);
    logic [8:0] en;
    en = '0;
    if (dst == DST_O_REG) en[EN_O_REG] = 1'b1;
    else                  en[dst]      = 1'b1;
    return en;
  endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Program-ROM and computational-unit control bundle driven by the sequencer.
interface instruction_sequencer_if;
  logic [7:0] pm_addr;
  logic [7:0] pm_data;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [3:0] nibble_ir;
  logic [3:0] source_sel;
  logic [8:0] reg_en;
  logic       i_sel;
  logic       x_sel;
  logic       y_sel;
  logic       r_eq_0;

  modport master (
    output pm_addr, pc, ir, nibble_ir, source_sel, reg_en, i_sel, x_sel, y_sel,
    input  pm_data, r_eq_0
  );

  modport slave (
    input  pm_addr, pc, ir, nibble_ir, source_sel, reg_en, i_sel, x_sel, y_sel,
    output pm_data, r_eq_0
  );
endinterface

// File: rtl/instruction_decode.sv
// Combinational decode of the instruction register into CU control strobes;
// everything is forced idle unless the sequencer is in its EXEC cycle.
module instruction_decode
  import micro_pkg::*;
(
  input  logic       exec,
  input  logic [7:0] ir,
  output logic [3:0] source_sel,
  output logic [8:0] reg_en,
  output logic       i_sel,
  output logic       is_jmp,
  output logic       is_jnz
);

  always_comb begin
    logic [2:0] dst;
    logic [2:0] src;
    logic       index;
    // NOTE: every output and temporary gets a default first so no path
    // through the branches below can infer a latch.
    source_sel = SRC_X0;
    reg_en     = '0;
    i_sel      = 1'b0;
    is_jmp     = 1'b0;
    is_jnz     = 1'b0;
    dst        = '0;
    src        = '0;
    index      = 1'b0;

    if (exec) begin
      if (ir[7] == 1'b0) begin
        dst        = ir[6:4];
        source_sel = SRC_NIBBLE;
        reg_en     = dst_onehot(dst);
        index      = (dst == DST_DM);
      end else if (ir[7:6] == OPC_MOVE) begin
        dst        = ir[5:3];
        src        = ir[2:0];
        source_sel = (src == dst) ? SRC_I_PINS : {1'b0, src};
        reg_en     = dst_onehot(dst);
        index      = (dst == DST_DM) || ((src == DST_DM) && (src != dst));
      end else if (ir[7:5] == OPC_ALU) begin
        reg_en[EN_R] = !((ir[3:0] == ALU_NOP_A) || (ir[3:0] == ALU_NOP_B));
      end else if (ir[7:4] == OPC_JMP) begin
        is_jmp = 1'b1;
      end else begin
        is_jnz = 1'b1;
      end

      // Any dm access post-increments i by m, unless i is itself the
      // destination, in which case the bus value wins.
      if (index && (dst != DST_I)) begin
        reg_en[EN_I] = 1'b1;
        i_sel        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Three-cycle FETCH/LATCH/EXEC sequencer: owns pc and ir, talks to the
// synchronous program ROM and strobes the computational unit in EXEC.
module instruction_sequencer
  import micro_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset_n,
  instruction_sequencer_if.master        bus
);

  state_t     state;
  logic [7:0] pc;
  logic [7:0] ir;

  logic [3:0] dec_source_sel;
  logic [8:0] dec_reg_en;
  logic       dec_i_sel;
  logic       is_jmp;
  logic       is_jnz;

  instruction_decode u_decode (
    .exec       (state == EXEC),
    .ir         (ir),
    .source_sel (dec_source_sel),
    .reg_en     (dec_reg_en),
    .i_sel      (dec_i_sel),
    .is_jmp     (is_jmp),
    .is_jnz     (is_jnz)
  );

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values, matching the hardware it describes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
      pc    <= 8'h00;
      ir    <= 8'h00;
    end else begin
      unique case (state)
        FETCH: begin
          pc    <= pc + 8'd1;
          state <= LATCH;
        end
        LATCH: begin
          ir    <= bus.pm_data;
          state <= EXEC;
        end
        EXEC: begin
          // pm_data now holds the byte after the opcode: the jump target.
          if (is_jmp || (is_jnz && !bus.r_eq_0)) pc <= bus.pm_data;
          else if (is_jnz)                       pc <= pc + 8'd1;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.pm_addr    = pc;
  assign bus.pc         = pc;
  assign bus.ir         = ir;
  assign bus.nibble_ir  = ir[3:0];
  assign bus.x_sel      = ir[4];
  assign bus.y_sel      = ir[3];
  assign bus.source_sel = dec_source_sel;
  assign bus.reg_en     = dec_reg_en;
  assign bus.i_sel      = dec_i_sel;

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Fetches 8-bit instructions from the synchronous program ROM, holds them in an instruction register, and drives the 4-bit computational unit's control inputs. It consumes the unit's zero flag for conditional jumps. It is the control end of the computational-unit interface: it produces `source_sel`, `reg_en`, `i_sel`, `x_sel`, `y_sel` and `nibble_ir`. Every instruction takes exactly three cycles.

## Interface
Parameters: none; all widths are fixed by the computational-unit interface.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pm_data`  in  8  ROM read data; during cycle N it equals PM[`pm_addr` sampled at the end of cycle N-1].
- `r_eq_0`  in  1  zero flag from the computational unit.
- `pm_addr`  out  8  ROM address; always equals `pc`.
- `pc`  out  8  program counter.
- `ir`  out  8  instruction register.
- `nibble_ir`  out  4  always `ir[3:0]`.
- `source_sel`  out  4  data-bus source select.
- `reg_en`  out  9  register enables. Bit order: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm, 8 o_reg.
- `i_sel`  out  1  0: `i` loads from the bus; 1: `i` loads `i + m`.
- `x_sel`, `y_sel`  out  1 each  ALU operand selects.

## Operation
FSM, one-hot or binary, with three states visited in order FETCH → LATCH → EXEC → FETCH:
- **FETCH:** `pm_addr` = `pc`. At the edge ending FETCH, `pc` <= `pc` + 1 (8-bit, wraps 0xFF→0x00).
- **LATCH:** `ir` <= `pm_data`. The ROM is simultaneously sampling `pc`, the byte after the opcode.
- **EXEC:** decoded `ir` drives the enables for this cycle only.

Outside EXEC:
- `reg_en` = 0, `source_sel` = 0, `i_sel` = 0.
- `x_sel` and `y_sel` always equal `ir[4]` and `ir[3]`.

Destination codes d ∈ 0..7 map to `reg_en` bits: 0→0, 1→1, 2→2, 3→3, 4→8 (o_reg), 5→5, 6→6, 7→7.

Instruction decode in EXEC:
- **Load immediate,** `ir[7]` = 0:
  - dst = `ir[6:4]`; `source_sel` = 8 (the CU takes `nibble_ir`).
  - Enable the dst bit.
- **Move,** `ir[7:6]` = 10:
  - dst = `ir[5:3]`, src = `ir[2:0]`.
  - `source_sel` = src, except src == dst gives `source_sel` = 9 (i_pins).
  - Enable the dst bit.
- **ALU,** `ir[7:5]` = 110:
  - `reg_en[4]` = 1, except `ir[3:0]` ∈ {1000, 1111} (the no-ops), where `reg_en[4]` = 0 and the flag is preserved.
  - `source_sel` = 0.
- **JMP,** `ir[7:4]` = 1110:
  - `pc` <= `pm_data`, which is the address byte at opcode address + 1.
  - No enables.
- **JNZ,** `ir[7:4]` = 1111:
  - If `r_eq_0` = 0, `pc` <= `pm_data`; otherwise `pc` <= `pc` + 1, skipping the address byte.
  - `ir[3:0]` is ignored.
- **Index side effect:** applies to a load or move that writes dm (dst = 7), or a move that reads dm (src = 7, src ≠ dst).
  - If dst ≠ 6: `reg_en[6]` = 1, `i_sel` = 1 (post-increment by m).
  - If dst = 6: `i_sel` = 0 (bus wins).
  - A move with src = dst = 7 (i_pins → dm) also increments.
- **Non-jumps** leave `pc` unchanged in EXEC; it already points to the next opcode.

## Timing
- Reset values (asynchronous, immediate on `reset_n` low):
  - `pc` = 0x00, `ir` = 0x00, state = FETCH.
  - `reg_en` = 0, `source_sel` = 0, `i_sel` = 0.
- Reset mid-instruction aborts it, and no enable pulses during reset. The first FETCH after release presents address 0x00.
- Enables assert for exactly one cycle (EXEC), 2 cycles after FETCH of the opcode. The CU commits at the edge ending EXEC.
- Instruction throughput: 1 per 3 cycles. Jumps are also 3 cycles and occupy 2 ROM bytes.
- `r_eq_0` is sampled during JNZ EXEC, so it reflects the last ALU instruction completed before it.
- `pc` wrap: a jump opcode at 0xFF reads its address byte from 0x00; a not-taken JNZ there resumes at 0x01.

## Structure
- **Shared package** `micro_pkg`:
  - opcode-field constants
  - state enum {FETCH, LATCH, EXEC}
  - `source_sel` codes (0–9)
  - `reg_en` bit indices
  - destination-code map
  - ALU no-op nibbles
- **Sub-module** `instruction_decode`: purely combinational `ir` → {`source_sel`, `reg_en`, `i_sel`, `is_jmp`, `is_jnz`}, gated by `exec`.
- **Top** `instruction_sequencer`: holds the FSM, `pc` and `ir`.

## Test plan
- **Reset:** `reset_n` low in LATCH of a non-zero `pc` → `pc` = 0, `reg_en` = 0 immediately; after release, `pm_addr` = 0x00 in FETCH.
- **Load and move:**
  - PM[0] = 0x3A → EXEC: `source_sel` = 8, `reg_en` = 0x008, `nibble_ir` = 0xA.
  - PM[1] = 0x94 (move dst 2, src 4) → `source_sel` = 4, `reg_en` = 0x004.
- **i_pins and dm:**
  - 0xA4 (move dst 4, src 4) → `source_sel` = 9, `reg_en` = 0x100.
  - 0x7C (load dm) → `reg_en` = 0x0C0, `i_sel` = 1.
  - 0xB7 (move dst 6, src 7) → `reg_en` = 0x040, `i_sel` = 0.
- **ALU:**
  - 0xD2 → `reg_en` = 0x010, `x_sel` = 1, `y_sel` = 0.
  - 0xC8 and 0xCF → `reg_en` = 0.
- **Jumps:**
  - PM[4..5] = E0,20 → `pc` = 0x20 after EXEC.
  - PM[0x20..0x21] = F0,40: with `r_eq_0` = 0 → `pc` = 0x40; with `r_eq_0` = 1 → `pc` = 0x22.
- **Wrap:** PM[0xFF] = 0xF0, PM[0x00] = 0x10, `r_eq_0` = 1 → next FETCH at 0x01.
